// File: rtl/vector_stream_tx.sv
// Parallel-load vector serializer: two-slot buffer feeding a valid/ready element stream.
// Optional framing output output_last enabled by defining VECTOR_STREAM_TX_LAST_EN.
module vector_stream_tx #(
    parameter int unsigned M = 5,
    parameter int unsigned T = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [M*T-1:0] load_data,
    output logic           output_valid,
    input  logic           output_ready,
`ifdef VECTOR_STREAM_TX_LAST_EN
    output logic [T-1:0]   output_data,
    output logic           output_last
`else
    output logic [T-1:0]   output_data
`endif
);

    localparam int unsigned IdxW = (M > 1) ? $clog2(M) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(M - 1);

    logic [M*T-1:0] active_q;
    logic [M*T-1:0] pending_q;
    logic           active_full_q;
    logic           pending_full_q;
    logic [IdxW-1:0] idx_q;

    logic load_fire;
    logic out_fire;
    logic finishing;

    assign load_ready   = !pending_full_q;
    assign output_valid = active_full_q;
    assign load_fire    = load_valid && load_ready;
    assign out_fire     = output_valid && output_ready;
    assign finishing    = out_fire && (idx_q == LastIdx);

    // Element select is driven purely from registers.
    always_comb begin
        output_data = '0;
        for (int unsigned k = 0; k < M; k++) begin
            if (idx_q == IdxW'(k)) begin
                output_data = active_q[k*T +: T];
            end
        end
    end

`ifdef VECTOR_STREAM_TX_LAST_EN
    assign output_last = active_full_q && (idx_q == LastIdx);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q       <= '0;
            pending_q      <= '0;
            active_full_q  <= 1'b0;
            pending_full_q <= 1'b0;
            idx_q          <= '0;
        end else begin
            if (out_fire) begin
                if (finishing) begin
                    idx_q <= '0;
                    if (pending_full_q) begin
                        active_q       <= pending_q;
                        pending_full_q <= 1'b0;
                    end else if (load_fire) begin
                        active_q <= load_data;
                    end else begin
                        active_full_q <= 1'b0;
                    end
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
            // A load coinciding with the final element was consumed above.
            if (load_fire && !finishing) begin
                if (!active_full_q) begin
                    active_q      <= load_data;
                    active_full_q <= 1'b1;
                end else begin
                    pending_q      <= load_data;
                    pending_full_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_stream_tx.sv
// Directed and randomized checks for vector_stream_tx (M=5, T=6).
module tb_vector_stream_tx;

    localparam int M = 5;
    localparam int T = 6;

    logic           clk;
    logic           reset;
    logic           load_valid;
    logic           load_ready;
    logic [M*T-1:0] load_data;
    logic           output_valid;
    logic           output_ready;
    logic [T-1:0]   output_data;
`ifdef VECTOR_STREAM_TX_LAST_EN
    logic           output_last;
`endif

    int checks = 0;
    int passed = 0;

    vector_stream_tx #(.M(M), .T(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
`ifdef VECTOR_STREAM_TX_LAST_EN
        .output_data  (output_data),
        .output_last  (output_last)
`else
        .output_data  (output_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [M*T-1:0] vec(input int first);
        logic [M*T-1:0] v;
        v = '0;
        for (int k = 0; k < M; k++) v[k*T +: T] = T'(first + k);
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; load_valid = 1'b0; output_ready = 1'b0; load_data = '0;
        #3;
        checks++; if (output_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", output_valid); else passed++;
        checks++; if (load_ready !== 1'b1) $display("FAIL reset_load_ready got %b want 1", load_ready); else passed++;
        checks++; if (output_data !== '0) $display("FAIL reset_data got %0d want 0", output_data); else passed++;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_basic();
        output_ready = 1'b1; load_valid = 1'b1; load_data = vec(1);
        step();
        load_valid = 1'b0; load_data = '0;
        for (int i = 0; i < M; i++) begin
            checks++; if (output_valid !== 1'b1) $display("FAIL basic_valid[%0d] got %b want 1", i, output_valid); else passed++;
            checks++; if (output_data !== T'(i + 1)) $display("FAIL basic_data[%0d] got %0d want %0d", i, output_data, i + 1); else passed++;
            checks++; if (load_ready !== 1'b1) $display("FAIL basic_load_ready[%0d] got %b want 1", i, load_ready); else passed++;
            step();
        end
        checks++; if (output_valid !== 1'b0) $display("FAIL basic_idle_valid got %b want 0", output_valid); else passed++;
        checks++; if (load_ready !== 1'b1) $display("FAIL basic_idle_load_ready got %b want 1", load_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        output_ready = 1'b1; load_valid = 1'b1; load_data = vec(1);
        step();
        checks++; if (output_data !== T'(1)) $display("FAIL b2b_data[0] got %0d want 1", output_data); else passed++;
        checks++; if (load_ready !== 1'b1) $display("FAIL b2b_load_ready[0] got %b want 1", load_ready); else passed++;
        load_data = vec(6);
        step();
        load_valid = 1'b0; load_data = '0;
        for (int v = 2; v <= 10; v++) begin
            checks++; if (output_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b want 1", v, output_valid); else passed++;
            checks++; if (output_data !== T'(v)) $display("FAIL b2b_data[%0d] got %0d want %0d", v, output_data, v); else passed++;
            checks++;
            if (load_ready !== (v > 5)) $display("FAIL b2b_load_ready[%0d] got %b want %b", v, load_ready, (v > 5));
            else passed++;
            step();
        end
        checks++; if (output_valid !== 1'b0) $display("FAIL b2b_idle_valid got %b want 0", output_valid); else passed++;
    endtask

    task automatic test_backpressure();
        output_ready = 1'b1; load_valid = 1'b1; load_data = vec(1);
        step();
        load_valid = 1'b0;
        step();
        step();
        output_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (output_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d] got %b want 1", i, output_valid); else passed++;
            checks++; if (output_data !== T'(3)) $display("FAIL bp_hold_data[%0d] got %0d want 3", i, output_data); else passed++;
            step();
        end
        output_ready = 1'b1;
        for (int v = 3; v <= 5; v++) begin
            checks++; if (output_data !== T'(v)) $display("FAIL bp_resume_data[%0d] got %0d want %0d", v, output_data, v); else passed++;
            step();
        end
        checks++; if (output_valid !== 1'b0) $display("FAIL bp_idle_valid got %b want 0", output_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        output_ready = 1'b1; load_valid = 1'b1; load_data = vec(1);
        step();
        load_valid = 1'b0;
        step();
        step();
        step();
        checks++; if (output_data !== T'(4)) $display("FAIL rm_pre_data got %0d want 4", output_data); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (output_valid !== 1'b0) $display("FAIL rm_valid got %b want 0", output_valid); else passed++;
        checks++; if (load_ready !== 1'b1) $display("FAIL rm_load_ready got %b want 1", load_ready); else passed++;
        #1;
        reset = 1'b0;
        load_valid = 1'b1; load_data = vec(9);
        step();
        load_valid = 1'b0;
        for (int v = 9; v <= 13; v++) begin
            checks++; if (output_valid !== 1'b1) $display("FAIL rm_valid[%0d] got %b want 1", v, output_valid); else passed++;
            checks++; if (output_data !== T'(v)) $display("FAIL rm_data[%0d] got %0d want %0d", v, output_data, v); else passed++;
            step();
        end
        checks++; if (output_valid !== 1'b0) $display("FAIL rm_idle_valid got %b want 0", output_valid); else passed++;
    endtask

    task automatic test_random();
        logic [T-1:0] exp_q[$];
        logic [T-1:0] want;
        logic [31:0]  r;
        int loaded = 0;
        int cycles = 0;
        while ((loaded < 2000 || exp_q.size() != 0) && cycles < 60000) begin
            r = $urandom;
            load_data    = r[M*T-1:0];
            load_valid   = (loaded < 2000) && ($urandom_range(0, 1) == 1);
            output_ready = ($urandom_range(0, 1) == 1);
            if (output_valid && output_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_extra got %0d want none", output_data);
                end else begin
                    want = exp_q.pop_front();
                    if (output_data !== want) $display("FAIL rand_data got %0d want %0d", output_data, want);
                    else passed++;
                end
            end
            if (load_valid && load_ready) begin
                for (int k = 0; k < M; k++) exp_q.push_back(load_data[k*T +: T]);
                loaded++;
            end
            step();
            cycles++;
        end
        checks++;
        if (cycles >= 60000) $display("FAIL rand_timeout got %0d left want 0", exp_q.size());
        else passed++;
        load_valid = 1'b0; output_ready = 1'b1;
        step();
        checks++; if (output_valid !== 1'b0) $display("FAIL rand_idle_valid got %b want 0", output_valid); else passed++;
    endtask

`ifdef VECTOR_STREAM_TX_LAST_EN
    task automatic test_last();
        output_ready = 1'b1; load_valid = 1'b1; load_data = vec(1);
        step();
        load_valid = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            checks++;
            if (output_last !== (v == 5)) $display("FAIL last[%0d] got %b want %b", v, output_last, (v == 5));
            else passed++;
            step();
        end
        checks++; if (output_last !== 1'b0) $display("FAIL last_idle got %b want 0", output_last); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef VECTOR_STREAM_TX_LAST_EN
        test_last();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
